// File: rtl/fsm_gpl_status_mc.sv
// Multi-channel GPL status qualifier: ON/OFF glitch filter per channel with rise/fall pulses.
// Optional sticky rise flags are enabled by defining FSM_GPL_STATUS_STICKY_EN.
module fsm_gpl_status_mc #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned ON_CYCLES  = 3,
    parameter int unsigned OFF_CYCLES = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                ena,
    input  logic [CHANNELS-1:0] gpl_status,
    input  logic [CHANNELS-1:0] sticky_clr,
    output logic [CHANNELS-1:0] specreg,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_active,
    output logic [CHANNELS-1:0] sticky
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StQual    = 2'b01,
        StActive  = 2'b10,
        StRelease = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] OnLast  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OffLast = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] spec_now, spec_nxt;
    logic [CHANNELS-1:0] rise_d, rise_q, fall_d, fall_q;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (ena) begin
                unique case (state_q[i])
                    StIdle: begin
                        if (gpl_status[i]) begin
                            if (ON_CYCLES == 1) begin
                                state_d[i] = StActive;
                            end else begin
                                state_d[i] = StQual;
                                cnt_d[i]   = CntOne;
                            end
                        end
                    end
                    StQual: begin
                        if (!gpl_status[i]) begin
                            state_d[i] = StIdle;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == OnLast) begin
                            state_d[i] = StActive;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CntOne;
                        end
                    end
                    StActive: begin
                        if (!gpl_status[i]) begin
                            if (OFF_CYCLES == 1) begin
                                state_d[i] = StIdle;
                            end else begin
                                state_d[i] = StRelease;
                                cnt_d[i]   = CntOne;
                            end
                        end
                    end
                    StRelease: begin
                        if (gpl_status[i]) begin
                            state_d[i] = StActive;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == OffLast) begin
                            state_d[i] = StIdle;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CntOne;
                        end
                    end
                endcase
            end
            spec_now[i] = (state_q[i] == StActive) || (state_q[i] == StRelease);
            spec_nxt[i] = (state_d[i] == StActive) || (state_d[i] == StRelease);
        end
    end

    // Pulses are registered alongside the state so they coincide with the specreg edge.
    assign rise_d = spec_nxt & ~spec_now;
    assign fall_d = spec_now & ~spec_nxt;

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign specreg    = spec_now;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_active = |spec_now;

`ifdef FSM_GPL_STATUS_STICKY_EN
    logic [CHANNELS-1:0] sticky_q;

    // Set wins over a simultaneous clear; clearing works regardless of ena.
    always_ff @(posedge clk) begin
        if (arst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~sticky_clr) | rise_d;
        end
    end

    assign sticky = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = ^sticky_clr;
    assign sticky            = '0;
`endif

endmodule

// File: tb/tb_fsm_gpl_status_mc.sv
// Directed self-checking bench for fsm_gpl_status_mc (CHANNELS=4, ON_CYCLES=3, OFF_CYCLES=2).
// Sticky expectations follow FSM_GPL_STATUS_STICKY_EN.
module tb_fsm_gpl_status_mc;

`ifdef FSM_GPL_STATUS_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst;
    logic       ena;
    logic [3:0] gpl_status;
    logic [3:0] sticky_clr;
    logic [3:0] specreg, rise_pulse, fall_pulse, sticky;
    logic       any_active;

    int total = 0;
    int bad   = 0;

    fsm_gpl_status_mc #(
        .CHANNELS  (4),
        .ON_CYCLES (3),
        .OFF_CYCLES(2),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .ena       (ena),
        .gpl_status(gpl_status),
        .sticky_clr(sticky_clr),
        .specreg   (specreg),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_active(any_active),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] sx(input logic [3:0] v);
        return STICKY ? v : 4'h0;
    endfunction

    // Check every output; any_active is derived from the expected specreg.
    task automatic expect_all(input string tag, input logic [3:0] sp, input logic [3:0] rp,
                              input logic [3:0] fp, input logic [3:0] st);
        chk({tag, ".specreg"}, specreg, sp);
        chk({tag, ".rise"}, rise_pulse, rp);
        chk({tag, ".fall"}, fall_pulse, fp);
        chk({tag, ".any"}, {3'b000, any_active}, {3'b000, |sp});
        chk({tag, ".sticky"}, sticky, sx(st));
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later.
    task automatic cyc(input logic [3:0] g, input logic e, input logic [3:0] clr);
        gpl_status = g;
        ena        = e;
        sticky_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst       = 1'b1;
        ena        = 1'b1;
        gpl_status = 4'hF;
        sticky_clr = 4'h0;

        // Reset held with all inputs active
        for (int i = 0; i < 4; i++) cyc(4'hF, 1'b1, 4'h0);
        expect_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);

        arst = 1'b0;
        cyc(4'hF, 1'b1, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("rel_e2", 4'h0, 4'h0, 4'h0, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("rel_e3", 4'hF, 4'hF, 4'h0, 4'hF);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("rel_e4", 4'hF, 4'h0, 4'h0, 4'hF);

        // ch0 down, sticky cleared on the way
        cyc(4'hE, 1'b1, 4'hF);
        expect_all("ch0dn_e1", 4'hF, 4'h0, 4'h0, 4'h0);
        cyc(4'hE, 1'b1, 4'hF);
        expect_all("ch0dn_e2", 4'hE, 4'h0, 4'h1, 4'h0);

        // Glitch reject then genuine assert on ch0
        cyc(4'hF, 1'b1, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("glitch_hi2", 4'hE, 4'h0, 4'h0, 4'h0);
        cyc(4'hE, 1'b1, 4'h0);
        expect_all("glitch_lo", 4'hE, 4'h0, 4'h0, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("qual_e2", 4'hE, 4'h0, 4'h0, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("qual_e3", 4'hF, 4'h1, 4'h0, 4'h1);

        // Release bounce on ch1
        cyc(4'hD, 1'b1, 4'h0);
        expect_all("bounce_lo1", 4'hF, 4'h0, 4'h0, 4'h1);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("bounce_hi", 4'hF, 4'h0, 4'h0, 4'h1);
        cyc(4'hD, 1'b1, 4'h0);
        expect_all("bounce_lo_a", 4'hF, 4'h0, 4'h0, 4'h1);
        cyc(4'hD, 1'b1, 4'h0);
        expect_all("bounce_lo_b", 4'hD, 4'h0, 4'h2, 4'h1);
        cyc(4'hD, 1'b1, 4'h0);
        expect_all("bounce_after", 4'hD, 4'h0, 4'h0, 4'h1);

        // ch2 down, then qualify across a freeze
        cyc(4'h9, 1'b1, 4'h0);
        cyc(4'h9, 1'b1, 4'h0);
        expect_all("ch2dn", 4'h9, 4'h0, 4'h4, 4'h1);
        cyc(4'hD, 1'b1, 4'h0);
        cyc(4'hD, 1'b1, 4'h0);
        expect_all("frz_pre", 4'h9, 4'h0, 4'h0, 4'h1);
        for (int i = 0; i < 5; i++) begin
            cyc(4'hD, 1'b0, 4'h0);
            expect_all("frz_hold", 4'h9, 4'h0, 4'h0, 4'h1);
        end
        cyc(4'hD, 1'b1, 4'h0);
        expect_all("frz_done", 4'hD, 4'h4, 4'h0, 4'h5);

        // Independence: ch0 rises on the edge ch3 falls
        cyc(4'hC, 1'b1, 4'h0);
        cyc(4'hC, 1'b1, 4'h0);
        expect_all("ind_ch0dn", 4'hC, 4'h0, 4'h1, 4'h5);
        cyc(4'hD, 1'b1, 4'h0);
        cyc(4'h5, 1'b1, 4'h0);
        expect_all("ind_e2", 4'hC, 4'h0, 4'h0, 4'h5);
        cyc(4'h5, 1'b1, 4'h0);
        expect_all("ind_e3", 4'h5, 4'h1, 4'h8, 4'h5);
        cyc(4'h0, 1'b1, 4'h0);
        cyc(4'h0, 1'b1, 4'h0);
        expect_all("all_low", 4'h0, 4'h0, 4'h5, 4'h5);

        // Sticky behaviour on ch1
        cyc(4'h2, 1'b1, 4'h0);
        cyc(4'h2, 1'b1, 4'h0);
        cyc(4'h2, 1'b1, 4'h0);
        expect_all("stk_rise", 4'h2, 4'h2, 4'h0, 4'h7);
        cyc(4'h0, 1'b1, 4'h0);
        cyc(4'h0, 1'b1, 4'h0);
        expect_all("stk_hold", 4'h0, 4'h0, 4'h2, 4'h7);
        cyc(4'h2, 1'b1, 4'h0);
        cyc(4'h2, 1'b1, 4'h0);
        cyc(4'h2, 1'b1, 4'h2);
        expect_all("stk_setwins", 4'h2, 4'h2, 4'h0, 4'h7);
        cyc(4'h2, 1'b1, 4'h2);
        expect_all("stk_clr", 4'h2, 4'h0, 4'h0, 4'h5);
        cyc(4'h2, 1'b0, 4'h5);
        expect_all("stk_clr_frz", 4'h2, 4'h0, 4'h0, 4'h0);

        // Reset mid-qualification discards progress
        cyc(4'hF, 1'b1, 4'h0);
        arst = 1'b1;
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("midrst", 4'h0, 4'h0, 4'h0, 4'h0);
        arst = 1'b0;
        cyc(4'hF, 1'b1, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("midrst_e2", 4'h0, 4'h0, 4'h0, 4'h0);
        cyc(4'hF, 1'b1, 4'h0);
        expect_all("midrst_e3", 4'hF, 4'hF, 4'h0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
